host_bus_bridge: RTL and testbench
==================================

Name: host_bus_bridge

Overview:
- Upstream host-side front end for the crypto coprocessor top.
- Converts a 32-bit valid/ready host command stream into the top's 256-bit register-write interface: one-hot 16-bit write enable plus 256-bit write bus.
- Serves reads by driving the 4-bit read select, capturing the 256-bit read data, and returning it as 32-bit response beats.
- Lets a narrow host program plaintext/IV/seed/CSR registers and read back ciphertext, generated and CSR values.

Parameters:
- DATA_W, 32, host beat width in bits.
- BUS_W, 256, register bus width; BUS_W must be a multiple of DATA_W; BEATS = BUS_W/DATA_W (default 8).
- WRITE_MASK, 16'h75DB, bit i = 1 means register index i accepts host writes.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  host command beat valid.
- cmd_ready  out  1  bridge can accept a command beat.
- cmd_write  in  1  1 = write transaction, 0 = read; sampled on the first beat only.
- cmd_addr  in  4  register index; sampled on the first beat only.
- cmd_wdata  in  DATA_W  write data beat; ignored for reads.
- rsp_valid  out  1  read response beat valid.
- rsp_ready  in  1  host accepts the response beat.
- rsp_rdata  out  DATA_W  read data beat.
- rsp_last  out  1  final response beat.
- wr_err  out  1  one-cycle pulse: write to a non-writable index was discarded.
- write_enable  out  16  one-hot register write strobe to the top.
- write_bus  out  BUS_W  assembled write data to the top.
- select_read  out  4  read select to the top.
- data_out  in  BUS_W  combinational read data from the top.

Behaviour:
- Beat accepted when cmd_valid && cmd_ready. Response beat consumed when rsp_valid && rsp_ready.
- Beat ordering is little-endian: beat k maps to bits [k*DATA_W +: DATA_W].
- Reset values: state IDLE, cmd_ready 1, rsp_valid 0, rsp_last 0, rsp_rdata 0, wr_err 0, write_enable 0, write_bus 0, select_read 0, beat counter 0, capture buffer 0.
- IDLE: cmd_ready = 1.
  - Write beat: latch addr, store beat into slot 0, count = 1, go to WR_COLLECT. If BEATS == 1, go to WR_COMMIT instead.
  - Read beat: select_read <= cmd_addr, go to RD_WAIT.
- WR_COLLECT: cmd_ready = 1.
  - Each accepted beat goes into slot count, and count increments.
  - The beat accepted with count == BEATS-1 moves the FSM to WR_COMMIT.
  - cmd_write and cmd_addr are ignored on beats after the first.
- WR_COMMIT (one cycle): cmd_ready = 0.
  - If WRITE_MASK[addr] is set: write_enable = 1 << addr for exactly this cycle, and write_bus equals the assembled word.
  - Otherwise: write_enable = 0 and wr_err = 1 for this cycle.
  - Next state IDLE.
  - write_enable and wr_err are registered. The pulse appears the cycle after the last beat is accepted, and the top register captures at the end of that cycle.
- write_bus holds its value between commits. It updates only on entry to WR_COMMIT and is never zeroed except by reset.
- RD_WAIT (one cycle): cmd_ready = 0.
  - select_read is stable and data_out has settled; capture data_out into the buffer at the end of the cycle.
  - Set idx = 0 and go to RD_SEND.
- RD_SEND: cmd_ready = 0, rsp_valid = 1.
  - rsp_rdata = buffer[idx*DATA_W +: DATA_W]; rsp_last = (idx == BEATS-1).
  - On consume: idx increments; after consuming the last beat go to IDLE.
  - While rsp_ready is low, rsp_valid, rsp_rdata and rsp_last are held stable.
- Read latency: first rsp_valid is asserted 2 cycles after the cycle in which the read command is accepted.
- select_read holds its last read index until the next read.
- Later top-side changes to data_out do not affect a response in flight, because data is served from the buffer.
- write_enable is never multi-hot. At most one transaction is in flight; no overlap between reads and writes.
- Reset mid-operation (any state): a partial write is discarded with no write_enable pulse; a partial response is aborted, rsp_valid drops immediately (asynchronous reset).
- A cmd_valid gap inside a write burst is legal; the counter simply waits.

Test Plan:
- Write to addr 0 with beats 32'h00000000..32'h00000007 (beat k = k) -> write_enable == 16'h0001 for exactly one cycle; write_bus == {8'h07 word, ..., 8'h00 word} with bits [31:0] = 0 and bits [255:224] = 7; cmd_ready low in that cycle.
- Write addr 3 (beats 32'hA5,0,...) -> write_enable == 16'h0008, write_bus[7:0] == 8'hA5. Then write addr 2 -> wr_err pulses once, write_enable stays 0, write_bus unchanged from the addr-3 value.
- Read addr 5 with data_out = 256'h...1111_2222 (beat0 = 32'h11112222) -> select_read == 5; rsp_valid 2 cycles after accept; 8 beats with beat0 == 32'h11112222; rsp_last only on beat 8.
- Read with rsp_ready toggled 1,0,0,1,... and data_out changed during RD_SEND -> beats held stable while stalled; returned data equals the value captured in RD_WAIT.
- Write with cmd_valid gaps and cmd_addr/cmd_write changed on beats 2..8 -> commit goes to the first-beat address, data complete and ordered.
- Assert reset after 4 write beats, then deassert -> no write_enable pulse; next full write commits correctly from slot 0; rsp_valid 0 throughout.

Source files
------------

// File: rtl/host_bus_bridge_if.sv
// host_bus_bridge_if
// Groups the host command/response handshake and the register-bus signals
// that connect the host_bus_bridge to its host and to the coprocessor top.
//   cmd_*        : host command beats (valid/ready, write flag, index, data)
//   rsp_*        : read response beats back to the host
//   wr_err       : pulse when a write to a read-only index is dropped
//   write_enable : one-hot register write strobe toward the top
//   write_bus    : assembled register write data toward the top
//   select_read  : register read select toward the top
//   data_out     : combinational read data coming back from the top
// Modports: slave = the bridge itself, master = host plus top side.
interface host_bus_bridge_if #(
   parameter int DATA_W = 32,
   parameter int BUS_W  = 256
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [3:0]        cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_last;
   logic              wr_err;
   logic [15:0]       write_enable;
   logic [BUS_W-1:0]  write_bus;
   logic [3:0]        select_read;
   logic [BUS_W-1:0]  data_out;

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, data_out,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_last, wr_err,
             write_enable, write_bus, select_read
   );

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, data_out,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_last, wr_err,
             write_enable, write_bus, select_read
   );
endinterface

// File: rtl/host_bus_bridge.sv
// host_bus_bridge
// Host-side front end of the crypto coprocessor. Narrow host write bursts
// (BEATS beats of DATA_W bits, little-endian) are assembled into one BUS_W
// word and committed with a one-cycle one-hot write_enable pulse. Reads drive
// select_read, capture data_out into a buffer and stream it back as BEATS
// response beats with rsp_last on the final one.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset, clears all state
//   bus   : host_bus_bridge_if.slave (command, response and register bus)
module host_bus_bridge #(
   parameter int          DATA_W     = 32,
   parameter int          BUS_W      = 256,
   parameter logic [15:0] WRITE_MASK = 16'h75DB
) (
   input logic              clock,
   input logic              reset,
   host_bus_bridge_if.slave bus
);

   localparam int BEATS = BUS_W / DATA_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {
      IDLE,
      WR_COLLECT,
      WR_COMMIT,
      RD_WAIT,
      RD_SEND
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              cmd_ready;
   logic              rsp_valid;
   logic              last_beat;
   logic              cmd_fire;
   logic              rsp_fire;
   logic [3:0]        addr_q;
   logic [3:0]        commit_addr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  idx;
   logic [CNT_W-1:0]  slot;
   logic [BUS_W-1:0]  buffer;
   logic [BUS_W-1:0]  merged;
   logic [BUS_W-1:0]  write_bus_q;
   logic [15:0]       write_enable_q;
   logic              wr_err_q;
   logic [3:0]        select_read_q;

   assign cmd_fire = bus.cmd_valid && cmd_ready;
   assign rsp_fire = rsp_valid && bus.rsp_ready;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs. last_beat marks the cycle in which the
   // final write beat is accepted, i.e. the cycle before WR_COMMIT.
   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      rsp_valid  = 1'b0;
      last_beat  = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               if (bus.cmd_write) begin
                  if (BEATS == 1) begin
                     last_beat  = 1'b1;
                     state_next = WR_COMMIT;
                  end else begin
                     state_next = WR_COLLECT;
                  end
               end else begin
                  state_next = RD_WAIT;
               end
            end
         end
         WR_COLLECT: begin
            cmd_ready = 1'b1;
            if (bus.cmd_valid && (count == LAST_IDX)) begin
               last_beat  = 1'b1;
               state_next = WR_COMMIT;
            end
         end
         WR_COMMIT: begin
            state_next = IDLE;
         end
         RD_WAIT: begin
            state_next = RD_SEND;
         end
         RD_SEND: begin
            rsp_valid = 1'b1;
            if (bus.rsp_ready && (idx == LAST_IDX)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The buffer with the current beat dropped into its slot; on the last beat
   // this is the complete word handed to write_bus. The first beat always
   // lands in slot 0 regardless of what count holds in IDLE.
   always_comb begin
      slot                         = (state == IDLE) ? '0 : count;
      merged                       = buffer;
      merged[slot*DATA_W +: DATA_W] = bus.cmd_wdata;
      commit_addr                  = (state == IDLE) ? bus.cmd_addr : addr_q;
   end

   // Datapath. The buffer is shared: it assembles write beats and holds the
   // captured read word, since only one transaction is ever in flight.
   // write_bus only moves on a commit to a writable index, so a discarded
   // write leaves the top's view of the bus untouched.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q         <= '0;
         count          <= '0;
         idx            <= '0;
         buffer         <= '0;
         write_bus_q    <= '0;
         write_enable_q <= '0;
         wr_err_q       <= 1'b0;
         select_read_q  <= '0;
      end else begin
         write_enable_q <= '0;
         wr_err_q       <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_fire) begin
                  if (bus.cmd_write) begin
                     buffer <= merged;
                     addr_q <= bus.cmd_addr;
                     count  <= CNT_W'(1);
                  end else begin
                     select_read_q <= bus.cmd_addr;
                  end
               end
            end
            WR_COLLECT: begin
               if (cmd_fire) begin
                  buffer <= merged;
                  count  <= count + 1'b1;
               end
            end
            RD_WAIT: begin
               buffer <= bus.data_out;
               idx    <= '0;
            end
            RD_SEND: begin
               if (rsp_fire) begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
         if (last_beat) begin
            count <= '0;
            if (WRITE_MASK[commit_addr]) begin
               write_bus_q    <= merged;
               write_enable_q <= 16'(1) << commit_addr;
            end else begin
               wr_err_q <= 1'b1;
            end
         end
      end
   end

   assign bus.cmd_ready    = cmd_ready;
   assign bus.rsp_valid    = rsp_valid;
   assign bus.rsp_rdata    = rsp_valid ? buffer[idx*DATA_W +: DATA_W] : '0;
   assign bus.rsp_last     = rsp_valid && (idx == LAST_IDX);
   assign bus.wr_err       = wr_err_q;
   assign bus.write_enable = write_enable_q;
   assign bus.write_bus    = write_bus_q;
   assign bus.select_read  = select_read_q;

endmodule

// File: tb/tb_host_bus_bridge.sv
// tb_host_bus_bridge
// Scoreboard bench for host_bus_bridge: stimulus tasks push expected commits
// and response beats into queues, and two negedge monitors pop and compare
// whenever the bridge presents a write pulse or a response beat.
module tb_host_bus_bridge;

   localparam logic [15:0] MASK = 16'h75DB;

   typedef struct {
      logic [15:0]  we;
      logic         err;
      logic [255:0] wbus;
   } commit_t;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   host_bus_bridge_if bus ();

   host_bus_bridge dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   commit_t      commit_q[$];
   beat_t        rsp_q[$];
   commit_t      exp_commit;
   beat_t        exp_beat;
   int           pass_count  = 0;
   int           check_count = 0;
   logic [255:0] model_bus;
   logic         held_valid;
   logic [31:0]  held_data;
   logic         held_last;

   task automatic check_output(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
      end
   endtask

   task automatic report_timeout(input string name);
      check_count++;
      $display("[TB] FAIL %s: actual timeout required DUT event", name);
   endtask

   function automatic logic [255:0] make_data(input logic [31:0] base, input logic [31:0] step);
      logic [255:0] d;
      d = '0;
      for (int k = 0; k < 8; k++) begin
         d[k*32 +: 32] = base + 32'(k) * step;
      end
      return d;
   endfunction

   // Commit monitor: any write pulse or error pulse must match the next
   // expected commit, with cmd_ready low in that same cycle.
   always @(negedge clock) begin
      if (!reset && (bus.write_enable != 16'h0 || bus.wr_err)) begin
         if (commit_q.size() == 0) begin
            check_output("unexpected_commit", {239'b0, bus.wr_err, bus.write_enable}, 256'h0);
         end else begin
            exp_commit = commit_q.pop_front();
            check_output("commit_we", 256'(bus.write_enable), 256'(exp_commit.we));
            check_output("commit_err", 256'(bus.wr_err), 256'(exp_commit.err));
            check_output("commit_bus", bus.write_bus, exp_commit.wbus);
            check_output("commit_ready_low", 256'(bus.cmd_ready), 256'h0);
         end
      end
   end

   // Response monitor: beats consumed in order against the queue; a beat
   // stalled by rsp_ready low must reappear unchanged next cycle.
   always @(negedge clock) begin
      if (!reset && bus.rsp_valid) begin
         if (held_valid) begin
            check_output("stall_hold_data", 256'(bus.rsp_rdata), 256'(held_data));
            check_output("stall_hold_last", 256'(bus.rsp_last), 256'(held_last));
         end
         if (rsp_q.size() == 0) begin
            check_output("unexpected_rsp", {223'b0, bus.rsp_last, bus.rsp_rdata}, 256'h0);
         end else if (bus.rsp_ready) begin
            exp_beat = rsp_q.pop_front();
            check_output("rsp_data", 256'(bus.rsp_rdata), 256'(exp_beat.data));
            check_output("rsp_last", 256'(bus.rsp_last), 256'(exp_beat.last));
         end
         held_valid = !bus.rsp_ready;
         held_data  = bus.rsp_rdata;
         held_last  = bus.rsp_last;
      end else begin
         held_valid = 1'b0;
      end
   end

   task automatic wait_accept(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clock);
         if (bus.cmd_ready) begin
            @(posedge clock);
            #1;
            done = 1'b1;
         end
      end
      if (!done) report_timeout(name);
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clock);
         #1;
         if (commit_q.size() == 0 && rsp_q.size() == 0) done = 1'b1;
      end
      if (!done) report_timeout("drain");
   endtask

   // Full write burst; later beats carry junk write/addr, optional valid gaps.
   task automatic write_txn(input logic [3:0] addr, input logic [255:0] data, input bit gaps);
      commit_t c;
      if (MASK[addr]) begin
         model_bus = data;
         c.we      = 16'(1) << addr;
         c.err     = 1'b0;
      end else begin
         c.we      = 16'h0;
         c.err     = 1'b1;
      end
      c.wbus = model_bus;
      commit_q.push_back(c);
      for (int k = 0; k < 8; k++) begin
         if (gaps && (k % 3 == 1)) begin
            bus.cmd_valid = 1'b0;
            repeat (2) @(posedge clock);
            #1;
         end
         bus.cmd_valid = 1'b1;
         bus.cmd_write = (k == 0) ? 1'b1 : (k % 2 == 1);
         bus.cmd_addr  = (k == 0) ? addr : ~addr;
         bus.cmd_wdata = data[k*32 +: 32];
         wait_accept("write_accept");
      end
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
   endtask

   // Read with latency checks; data_out is replaced once the capture is done.
   task automatic read_txn(input logic [3:0] addr, input logic [255:0] data,
                           input logic [255:0] later, input bit stall);
      logic [3:0] pat;
      beat_t      b;
      bit         done;
      pat           = 4'b1001;
      bus.data_out  = data;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         b.data = data[k*32 +: 32];
         b.last = (k == 7);
         rsp_q.push_back(b);
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = 32'hFFFF_FFFF;
      wait_accept("read_accept");
      bus.cmd_valid = 1'b0;
      @(negedge clock);
      check_output("read_valid_early", 256'(bus.rsp_valid), 256'h0);
      check_output("select_read", 256'(bus.select_read), 256'(addr));
      @(posedge clock);
      #1;
      bus.data_out = later;
      if (stall) bus.rsp_ready = pat[0];
      @(negedge clock);
      check_output("read_latency", 256'(bus.rsp_valid), 256'h1);
      done = (rsp_q.size() == 0);
      for (int i = 1; i < 200 && !done; i++) begin
         @(posedge clock);
         #1;
         if (stall) bus.rsp_ready = pat[i % 4];
         done = (rsp_q.size() == 0);
      end
      if (!done) report_timeout("read_drain");
      bus.rsp_ready = 1'b1;
   endtask

   initial begin
      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 4'h0;
      bus.cmd_wdata = 32'h0;
      bus.rsp_ready = 1'b1;
      bus.data_out  = '0;
      model_bus     = '0;
      held_valid    = 1'b0;
      held_data     = '0;
      held_last     = 1'b0;

      repeat (2) @(posedge clock);
      @(negedge clock);
      check_output("rst_cmd_ready", 256'(bus.cmd_ready), 256'h1);
      check_output("rst_rsp_valid", 256'(bus.rsp_valid), 256'h0);
      check_output("rst_rsp_last", 256'(bus.rsp_last), 256'h0);
      check_output("rst_rsp_rdata", 256'(bus.rsp_rdata), 256'h0);
      check_output("rst_wr_err", 256'(bus.wr_err), 256'h0);
      check_output("rst_write_enable", 256'(bus.write_enable), 256'h0);
      check_output("rst_write_bus", bus.write_bus, 256'h0);
      check_output("rst_select_read", 256'(bus.select_read), 256'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      $display("[TB] write addr 0, beat k = k");
      write_txn(4'd0, make_data(32'h0, 32'h1), 1'b0);
      wait_drain();
      check_output("wbus_low_word", 256'(bus.write_bus[31:0]), 256'h0);
      check_output("wbus_high_word", 256'(bus.write_bus[255:224]), 256'h7);

      $display("[TB] write addr 3 then rejected write addr 2");
      write_txn(4'd3, {224'h0, 32'h0000_00A5}, 1'b0);
      wait_drain();
      check_output("wbus_a5", 256'(bus.write_bus[7:0]), 256'hA5);
      write_txn(4'd2, make_data(32'hDEAD_0000, 32'h1), 1'b0);
      wait_drain();
      check_output("wbus_unchanged", bus.write_bus, {224'h0, 32'h0000_00A5});

      $display("[TB] read addr 5");
      read_txn(4'd5,
               256'h77777777_66666666_55555555_44444444_33333333_AAAABBBB_CCCCDDDD_11112222,
               256'h77777777_66666666_55555555_44444444_33333333_AAAABBBB_CCCCDDDD_11112222,
               1'b0);

      $display("[TB] read addr 9 with stalls and data_out changing");
      read_txn(4'd9,
               256'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C_4B4B4B4B_5A5A5A5A_69696969_78787878,
               256'hF0F0F0F0_E1E1E1E1_D2D2D2D2_C3C3C3C3_B4B4B4B4_A5A5A5A5_96969696_87878787,
               1'b1);

      $display("[TB] gapped write addr 4 with junk addr/write on later beats");
      write_txn(4'd4, make_data(32'hC0DE_0000, 32'h0000_0101), 1'b1);
      wait_drain();

      $display("[TB] reset in the middle of a write");
      for (int k = 0; k < 4; k++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_write = (k == 0);
         bus.cmd_addr  = 4'd6;
         bus.cmd_wdata = 32'hBAD0_0000 + 32'(k);
         wait_accept("partial_accept");
      end
      bus.cmd_valid = 1'b0;
      #2;
      reset = 1'b1;
      model_bus = '0;
      #1;
      check_output("midrst_cmd_ready", 256'(bus.cmd_ready), 256'h1);
      check_output("midrst_write_enable", 256'(bus.write_enable), 256'h0);
      check_output("midrst_write_bus", bus.write_bus, 256'h0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      write_txn(4'd7, make_data(32'h7000_0000, 32'h11), 1'b0);
      wait_drain();
      check_output("post_reset_bus", bus.write_bus, make_data(32'h7000_0000, 32'h11));

      check_output("commit_q_empty", 256'(commit_q.size()), 256'h0);
      check_output("rsp_q_empty", 256'(rsp_q.size()), 256'h0);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
